// File: rtl/udm_uart_tx.sv
// -----------------------------------------------------------------------------
// udm_uart_tx
// Buffered UART transmitter for the UDM debug bridge. Response bytes are queued
// in a small FIFO. Each byte is sent as an 8N1 or 8E1/8O1 frame: a start bit,
// eight data bits LSB first, an optional parity bit and one stop bit. Each bit
// lasts P clock cycles, where P is sampled from bitperiod_i when the frame
// starts.
//
// Ports
//   clk_i         system clock
//   arst_n_i      asynchronous active-low reset
//   bitperiod_i   bit duration in clk_i cycles (0 is treated as 1), per frame
//   cfg_i         parity mode: 00 none, 01 even, 10 odd, 11 none, per frame
//   data_i        byte to queue
//   valid_i       push request, accepted when ready_o is high
//   ready_o       FIFO not full
//   tx_o          serial line, idles high, registered
//   busy_o        FSM active or bytes still queued
//   fifo_count_o  number of queued bytes, not counting the byte in flight
// -----------------------------------------------------------------------------
module udm_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [31:0]                   bitperiod_i,
  input  logic [1:0]                    cfg_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage (no reset, so it can map onto distributed/block RAM)
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Serializer state
  state_t        state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   period_q, period_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          tx_q, tx_d;

  logic          push;
  logic          pop;
  logic          start_frame;
  logic          fifo_empty;
  logic          fifo_full;
  logic          timer_done;
  logic [7:0]    head;
  logic [31:0]   period_eff;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  // ready depends only on the full flag, so a pop never unblocks a push in the same cycle
  assign push       = valid_i && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign timer_done = (timer_q == 32'd0);
  assign period_eff = (bitperiod_i == 32'd0) ? 32'd1 : bitperiod_i;

  // FIFO pointer / occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Next-state logic. The bit timer is reloaded with P-1 on every bit boundary
  // and otherwise counts down; a boundary is reached when it hits zero.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (state_q != S_IDLE && !timer_done) timer_d = timer_q - 32'd1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      S_START: begin
        if (timer_done) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          timer_d   = period_q - 32'd1;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          timer_d = period_q - 32'd1;
          if (bit_idx_q == 3'd7) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // shift_q[0] always holds the bit currently on the line
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (timer_done) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          timer_d = period_q - 32'd1;
        end
      end
      S_STOP: begin
        if (timer_done) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;  // back-to-back: no idle gap after the stop bit
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame launch: pop the head byte and freeze P and the parity mode for
    // the whole frame. Odd parity is the inverted even parity (cfg bit 1).
    if (start_frame) begin
      pop       = 1'b1;
      state_d   = S_START;
      shift_d   = head;
      period_d  = period_eff;
      timer_d   = period_eff - 32'd1;
      par_en_d  = cfg_i[0] ^ cfg_i[1];
      par_bit_d = (^head) ^ cfg_i[1];
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= 32'd0;
      period_q  <= 32'd1;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

  assign ready_o      = !fifo_full;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count_o = count_q;

endmodule
